// File: rtl/int_mult_pipe.sv
// Fully pipelined signed/unsigned integer multiplier: registered partial products
// followed by a registered binary adder tree, with a tag carried alongside each operation.
module int_mult_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_signed,
  input  logic [DATA_WIDTH-1:0]     m_cand,
  input  logic [DATA_WIDTH-1:0]     m_plier,
  input  logic [TAG_WIDTH-1:0]      in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DATA_WIDTH-1:0]   result,
  output logic [TAG_WIDTH-1:0]      out_tag
);

  localparam int TREE_LEVELS = $clog2(DATA_WIDTH);
  localparam int NUM_PP      = 1 << TREE_LEVELS;
  localparam int PW          = 2 * DATA_WIDTH;

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
  // The whole pipe moves as one (adv); out_valid/result/out_tag stay stable until taken,
  // and in_ready is the only combinational path from inputs to outputs.
  logic adv;

  logic [PW-1:0]        node_q [TREE_LEVELS+1][NUM_PP];
  logic [PW-1:0]        node_d [TREE_LEVELS+1][NUM_PP];
  logic [TREE_LEVELS:0] valid_q, valid_d;
  logic [TAG_WIDTH-1:0] tag_q  [TREE_LEVELS+1];
  logic [TAG_WIDTH-1:0] tag_d  [TREE_LEVELS+1];
  logic [PW-1:0]        cand_ext;
  logic [PW-1:0]        pp_k;

  assign adv       = en & (~valid_q[TREE_LEVELS] | out_ready);
  assign in_ready  = adv & rst_n;
  assign out_valid = valid_q[TREE_LEVELS];
  assign result    = node_q[TREE_LEVELS][0];
  assign out_tag   = tag_q[TREE_LEVELS];

  always_comb begin
    node_d   = node_q;
    valid_d  = valid_q;
    tag_d    = tag_q;
    cand_ext = {{DATA_WIDTH{in_signed & m_cand[DATA_WIDTH-1]}}, m_cand};
    pp_k     = '0;
    if (adv) begin
      valid_d[0] = in_valid;
      if (in_valid) begin
        tag_d[0] = in_tag;
        // The multiplier MSB carries weight -2**(W-1) in signed mode, so its term is negated.
        for (int k = 0; k < DATA_WIDTH; k++) begin
          pp_k = (cand_ext & {PW{m_plier[k]}}) << k;
          if (in_signed && (k == DATA_WIDTH - 1)) begin
            pp_k = -pp_k;
          end
          node_d[0][k] = pp_k;
        end
        for (int k = DATA_WIDTH; k < NUM_PP; k++) begin
          node_d[0][k] = '0;
        end
      end
      for (int l = 1; l <= TREE_LEVELS; l++) begin
        valid_d[l] = valid_q[l-1];
        tag_d[l]   = tag_q[l-1];
        for (int i = 0; i < (NUM_PP >> l); i++) begin
          node_d[l][i] = node_q[l-1][2*i] + node_q[l-1][2*i+1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int l = 0; l <= TREE_LEVELS; l++) begin
        tag_q[l] <= '0;
        for (int i = 0; i < NUM_PP; i++) begin
          node_q[l][i] <= '0;
        end
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      node_q  <= node_d;
    end
  end

endmodule

// File: tb/tb_int_mult_pipe.sv
// Bench for int_mult_pipe: 32-bit directed/streaming/stall/reset tests, a 12-bit
// directed check, and exhaustive 8-bit (both modes) and 2-bit sweeps against a model.
module tb_int_mult_pipe;

  localparam int W    = 32;
  localparam int TW   = 4;
  localparam int LAT  = 6;   // cycles from presenting an op to seeing its result, W=32
  localparam int LAT12 = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main 32-bit DUT ----------------
  logic          en = 1'b0, in_valid = 1'b0, in_ready, in_signed = 1'b0;
  logic [W-1:0]  m_cand = '0, m_plier = '0;
  logic [TW-1:0] in_tag = '0, out_tag;
  logic          out_valid, out_ready = 1'b1;
  logic [2*W-1:0] result;

  int_mult_pipe #(.DATA_WIDTH(W), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .m_cand(m_cand), .m_plier(m_plier), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_tag(out_tag));

  // ---------------- 12-bit DUT ----------------
  logic          v12_in = 1'b0, rdy12, s12 = 1'b0, v12_out;
  logic [11:0]   a12 = '0, b12 = '0;
  logic [TW-1:0] t12_in = '0, t12_out;
  logic [23:0]   r12;
  logic          one = 1'b1;

  int_mult_pipe #(.DATA_WIDTH(12), .TAG_WIDTH(TW)) u12 (
    .clk(clk), .rst_n(rst_n), .en(one), .in_valid(v12_in), .in_ready(rdy12),
    .in_signed(s12), .m_cand(a12), .m_plier(b12), .in_tag(t12_in),
    .out_valid(v12_out), .out_ready(one), .result(r12), .out_tag(t12_out));

  // ---------------- 2-bit DUT ----------------
  logic          v2_in = 1'b0, rdy2, s2 = 1'b0, v2_out;
  logic [1:0]    a2 = '0, b2 = '0;
  logic [TW-1:0] t2_in = '0, t2_out;
  logic [3:0]    r2;

  int_mult_pipe #(.DATA_WIDTH(2), .TAG_WIDTH(TW)) u2 (
    .clk(clk), .rst_n(rst_n), .en(one), .in_valid(v2_in), .in_ready(rdy2),
    .in_signed(s2), .m_cand(a2), .m_plier(b2), .in_tag(t2_in),
    .out_valid(v2_out), .out_ready(one), .result(r2), .out_tag(t2_out));

  // ---------------- four 8-bit DUTs for the exhaustive sweep ----------------
  logic          xv_in = 1'b0;
  logic [TW-1:0] xt_in = '0;
  logic [7:0]    xa [4];
  logic [7:0]    xb [4];
  logic          xs [4];
  logic          xrdy [4];
  logic          xv_out [4];
  logic [15:0]   xr [4];
  logic [TW-1:0] xt_out [4];

  for (genvar j = 0; j < 4; j++) begin : g_x8
    int_mult_pipe #(.DATA_WIDTH(8), .TAG_WIDTH(TW)) u8 (
      .clk(clk), .rst_n(rst_n), .en(one), .in_valid(xv_in), .in_ready(xrdy[j]),
      .in_signed(xs[j]), .m_cand(xa[j]), .m_plier(xb[j]), .in_tag(xt_in),
      .out_valid(xv_out[j]), .out_ready(one), .result(xr[j]), .out_tag(xt_out[j]));
  end

  // ---------------- model and scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;

  logic [67:0] exp_q[$];    // {tag, 64-bit product}
  logic [67:0] exp8_q[$];   // {tag, four 16-bit products}
  logic [7:0]  exp2_q[$];   // {tag, 4-bit product}
  logic [27:0] exp12_q[$];  // {tag, 24-bit product}

  function automatic logic [127:0] model(input int w, input logic [63:0] a,
                                         input logic [63:0] b, input bit s);
    logic [127:0] ea, eb, mask;
    mask = (128'd1 << (2 * w)) - 128'd1;
    ea = {64'd0, a};
    eb = {64'd0, b};
    if (s && a[w-1]) ea = ea | ~((128'd1 << w) - 128'd1);
    if (s && b[w-1]) eb = eb | ~((128'd1 << w) - 128'd1);
    return (ea * eb) & mask;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin : compare
    logic [67:0]  e;
    logic [67:0]  e8;
    logic [7:0]   e2;
    logic [27:0]  e12;
    logic [127:0] p;
    logic [63:0]  hold_res;
    logic [TW-1:0] hold_tag;
    bit hold_v;
    hold_v = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete(); exp8_q.delete(); exp2_q.delete(); exp12_q.delete();
      end
      // main DUT
      check("in_ready", in_ready, rst_n & en & (~out_valid | out_ready));
      if (hold_v) begin
        check("hold_valid", out_valid, 1);
        check("hold_result", result, hold_res);
        check("hold_tag", out_tag, hold_tag);
      end
      if (rst_n && out_valid) begin
        check("out_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0 && en && out_ready) begin
          e = exp_q.pop_front();
          check("result", result, e[63:0]);
          check("out_tag", out_tag, e[67:64]);
        end
      end
      hold_v   = rst_n && out_valid && !(en && out_ready);
      hold_res = result;
      hold_tag = out_tag;
      if (rst_n && in_valid && in_ready) begin
        p = model(W, m_cand, m_plier, in_signed);
        exp_q.push_back({in_tag, p[63:0]});
      end
      // 8-bit sweep
      if (rst_n && (xv_out[0] || xv_out[1] || xv_out[2] || xv_out[3])) begin
        check("x8_expected", exp8_q.size() != 0, 1);
        if (exp8_q.size() != 0) begin
          e8 = exp8_q.pop_front();
          for (int j = 0; j < 4; j++) begin
            check("x8_valid", xv_out[j], 1);
            check("x8_result", xr[j], e8[16*j +: 16]);
            check("x8_tag", xt_out[j], e8[67:64]);
          end
        end
      end
      if (rst_n && xv_in && xrdy[0]) begin
        for (int j = 0; j < 4; j++) begin
          p = model(8, xa[j], xb[j], xs[j]);
          e8[16*j +: 16] = p[15:0];
        end
        e8[67:64] = xt_in;
        exp8_q.push_back(e8);
      end
      // 2-bit DUT
      if (rst_n && v2_out) begin
        check("x2_expected", exp2_q.size() != 0, 1);
        if (exp2_q.size() != 0) begin
          e2 = exp2_q.pop_front();
          check("x2_result", r2, e2[3:0]);
          check("x2_tag", t2_out, e2[7:4]);
        end
      end
      if (rst_n && v2_in && rdy2) begin
        p = model(2, a2, b2, s2);
        exp2_q.push_back({t2_in, p[3:0]});
      end
      // 12-bit DUT
      if (rst_n && v12_out) begin
        check("u12_expected", exp12_q.size() != 0, 1);
        if (exp12_q.size() != 0) begin
          e12 = exp12_q.pop_front();
          check("u12_result", r12, e12[23:0]);
          check("u12_tag", t12_out, e12[27:24]);
        end
      end
      if (rst_n && v12_in && rdy12) begin
        p = model(12, a12, b12, s12);
        exp12_q.push_back({t12_in, p[23:0]});
      end
    end
  end

  // ---------------- driver tasks (all called at #1 after a rising edge) ----------------
  task automatic single(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit s, input logic [TW-1:0] tag, input logic [2*W-1:0] exp_res);
    int c0;
    bit seen;
    check({name, "_model_pin"}, model(W, a, b, s), exp_res);
    m_cand = a; m_plier = b; in_signed = s; in_tag = tag; in_valid = 1'b1;
    @(negedge clk);
    c0 = cyc;
    check({name, "_accept"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        check({name, "_latency"}, cyc - c0, LAT);
        check({name, "_result"}, result, exp_res);
        check({name, "_tag"}, out_tag, tag);
      end
    end
    check({name, "_seen"}, seen, 1);
    @(posedge clk); #1;
  endtask

  task automatic single12(input string name, input logic [11:0] a, input logic [11:0] b,
                          input bit s, input logic [23:0] exp_res);
    int c0;
    bit seen;
    check({name, "_model_pin"}, model(12, a, b, s), exp_res);
    a12 = a; b12 = b; s12 = s; t12_in = 4'hA; v12_in = 1'b1;
    @(negedge clk);
    c0 = cyc;
    @(posedge clk); #1;
    v12_in = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (v12_out) begin
        seen = 1'b1;
        check({name, "_latency"}, cyc - c0, LAT12);
        check({name, "_result"}, r12, exp_res);
      end
    end
    check({name, "_seen"}, seen, 1);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                      input logic [TW-1:0] tag);
    bit done;
    m_cand = a; m_plier = b; in_signed = s; in_tag = tag; in_valid = 1'b1;
    done = 1'b0;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    check("send_accepted", done, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bit empty;
    empty = 1'b0;
    for (int t = 0; t < 100 && !empty; t++) begin
      @(posedge clk); #1;
      empty = (exp_q.size() == 0) && !out_valid;
    end
    check({name, "_drained"}, empty, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int c0;
    bit seen;
    for (int j = 0; j < 4; j++) begin
      xa[j] = '0; xb[j] = '0; xs[j] = 1'b0;
    end
    en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_out_tag", out_tag, 0);
    check("reset_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed products
    single("u_ffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd5, 64'hFFFF_FFFE_0000_0001);
    single("u_zero", 32'h0,         32'h1234,      1'b0, 4'd1, 64'h0);
    single("s_m3x7", 32'hFFFF_FFFD, 32'd7,         1'b1, 4'd2, 64'hFFFF_FFFF_FFFF_FFEB);
    single("s_minmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 4'd3, 64'h4000_0000_0000_0000);
    single("u_minmin", 32'h8000_0000, 32'h8000_0000, 1'b0, 4'd4, 64'h4000_0000_0000_0000);
    single("s_m1m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'd6, 64'h1);

    // streaming with a 3-cycle output stall, mixed modes
    fork
      begin
        for (int i = 0; i < 20; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)), 4'(i));
      end
      begin
        repeat (9) @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("stall_out_valid", out_valid, 1);
        check("stall_in_ready", in_ready, 0);
        repeat (3) @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain("stream");

    // en low for 2 cycles with 4 operations in flight
    c0 = cyc;
    send(32'd3, 32'd5, 1'b0, 4'd7);
    send(32'hFFFF_FFF0, 32'd16, 1'b1, 4'd8);
    send(32'd100, 32'd200, 1'b0, 4'd9);
    send(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 4'd10);
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("freeze_out_valid", out_valid, 0);
      @(posedge clk); #1;
    end
    en = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        check("freeze_latency", cyc - c0, LAT + 2);
        check("freeze_result", result, 64'd15);
      end
    end
    check("freeze_seen", seen, 1);
    @(posedge clk); #1;
    drain("freeze");

    // en low while a result waits: en overrides out_ready
    send(32'd9, 32'd9, 1'b0, 4'd11);
    repeat (5) @(posedge clk); #1;
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("en_hold_valid", out_valid, 1);
      check("en_hold_result", result, 64'd81);
      @(posedge clk); #1;
    end
    en = 1'b1;
    drain("en_hold");

    // reset with 5 operations in flight
    for (int i = 0; i < 5; i++) send(32'(i + 2), 32'd1000, 1'b0, 4'(i + 1));
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_out_tag", out_tag, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("rst_no_stale", out_valid, 0);
    end
    @(posedge clk); #1;

    // 12-bit instance
    single12("w12_s_min_max", 12'h800, 12'h7FF, 1'b1, 24'hC0_0800);
    single12("w12_s_minmin",  12'h800, 12'h800, 1'b1, 24'h40_0000);
    single12("w12_u_ffff",    12'hFFF, 12'hFFF, 1'b0, 24'hFF_E001);

    // exhaustive 8-bit in both modes (a-range split over two instances per mode), 2-bit full
    for (int c = 0; c < 32768; c++) begin
      for (int j = 0; j < 4; j++) begin
        xa[j] = {j[1], c[6:0]};
        xb[j] = c[14:7];
        xs[j] = j[0];
      end
      xt_in = c[3:0];
      xv_in = 1'b1;
      if (c < 32) begin
        a2 = c[1:0]; b2 = c[3:2]; s2 = c[4]; t2_in = c[3:0]; v2_in = 1'b1;
      end else begin
        v2_in = 1'b0;
      end
      @(posedge clk); #1;
    end
    xv_in = 1'b0;
    v2_in = 1'b0;
    repeat (10) @(posedge clk); #1;
    check("x8_drained", exp8_q.size(), 0);
    check("x2_drained", exp2_q.size(), 0);
    check("u12_drained", exp12_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/int_mult_pipe.md
Name: int_mult_pipe

Overview:
- Parametrised, fully pipelined integer multiplier for the int_alu datapath.
- Successor to the fixed-width radix-2 adder-tree multiplier:
  - width is generic and need not be a power of two;
  - signed or unsigned mode is selected per operation;
  - valid/ready handshake with backpressure;
  - a tag is carried alongside each operation.
- Sits between the ALU issue stage and the writeback arbiter; one new operation may be accepted every cycle.

Parameters:
- DATA_WIDTH, 32, operand width in bits (≥2, any value).
- TAG_WIDTH, 4, width of the opaque tag carried with each operation (≥1).
- TREE_LEVELS, $clog2(DATA_WIDTH), number of registered adder-tree levels (derived; do not override).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  global enable; when 0, the whole pipeline holds.
- in_valid  input  1  operand set present.
- in_ready  output  1  block accepts the operand set this cycle.
- in_signed  input  1  1 = two's-complement multiply, 0 = unsigned; sampled with the operands.
- m_cand  input  DATA_WIDTH  multiplicand.
- m_plier  input  DATA_WIDTH  multiplier.
- in_tag  input  TAG_WIDTH  tag, returned unchanged with the result.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- result  output  2*DATA_WIDTH  full-width product.
- out_tag  output  TAG_WIDTH  tag of the result.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - all stage valid bits, out_valid, result and out_tag clear to 0;
  - in-flight operations are discarded, not completed;
  - in_ready is 0 during reset.
- Advance condition: adv = en & (~out_valid | out_ready).
  - in_ready = adv (combinational). This is the only combinational input-to-output path.
  - Acceptance: in_valid & in_ready.
  - When adv=0, every stage register (data, valid, tag, mode) holds its value.
- Stage 0 (input register, on acceptance):
  - Generate DATA_WIDTH partial products PP[k] = (m_cand & {DATA_WIDTH{m_plier[k]}}) << k, each 2*DATA_WIDTH wide.
  - Unsigned mode: zero-extend m_cand.
  - Signed mode: sign-extend m_cand to 2*DATA_WIDTH. The PP for the multiplier MSB (k = DATA_WIDTH-1) is negated (two's complement) before the tree.
  - Pad the PP count up to 2**TREE_LEVELS with zero terms.
- Tree levels 1..TREE_LEVELS:
  - each level adds adjacent pairs and is registered;
  - all sums are modulo 2**(2*DATA_WIDTH); no overflow is possible into the result width.
- Latency: an operation accepted at edge N appears at the output at edge N+TREE_LEVELS+1, assuming no stalls.
  - DATA_WIDTH=32: 6 cycles. DATA_WIDTH=8: 4 cycles.
- Throughput: 1 operation/cycle while adv=1. Bubbles propagate as valid=0 stages.
- Output:
  - result and out_tag come from the last tree register;
  - out_valid is held with result stable until out_ready=1 (AXI-style);
  - result is not required to be 0 when out_valid=0.
- Simultaneous events:
  - out_ready=1 together with a full pipeline: output drains and a new input is accepted in the same cycle.
  - en=0 overrides out_ready: the output is not consumed and out_valid stays 1.
- Mode isolation: in_signed travels with its operation. Mixed signed/unsigned back-to-back operations must not interfere.
- Edge cases:
  - DATA_WIDTH=2: TREE_LEVELS=1.
  - Non-power-of-two widths (e.g. 12): pad to 16 PPs.
  - Signed: most-negative × most-negative yields +2**(2*DATA_WIDTH-2) exactly.

Test Plan:
1. Unsigned, DATA_WIDTH=32: 0xFFFFFFFF×0xFFFFFFFF, tag 5 -> after 6 cycles result=0xFFFFFFFE00000001, out_tag=5; 0×0x1234 -> 0.
2. Signed, DATA_WIDTH=32:
   - (-3)×7 -> result=0xFFFFFFFFFFFFFFEB;
   - 0x80000000×0x80000000 -> 0x4000000000000000;
   - the same operands unsigned -> 0x4000000000000000, with the 0xFFFFFFFF operands matching case 1.
3. Streaming with backpressure: 20 back-to-back random operations, out_ready held 0 for 3 cycles mid-stream -> in_ready drops in the same cycle as out_ready drops; no loss or duplication; results in order with matching tags versus a reference model.
4. en low for 2 cycles while 4 operations are in flight -> all registers frozen, out_valid unchanged; on resume, results complete with latency extended by exactly 2 cycles.
5. Reset mid-operation: assert rst_n=0 for 1 cycle with 5 operations in flight -> next cycle out_valid=0, result=0, out_tag=0; no stale result emerges over the following 10 cycles.
6. DATA_WIDTH=12 instance, signed: 0x800×0x7FF (-2048×2047) -> result=0xC00800 (24-bit), latency 5; exhaustive 8-bit instance over all 65536 pairs in both modes, compared against the model.
